// File: rtl/chunked_negator_pkg.sv
// Shared encodings and helpers for the chunked two's-complement sign unit.
package negator_pkg;

  typedef enum logic [1:0] {
    MODE_PASS = 2'b00,
    MODE_NEG  = 2'b01,
    MODE_ABS  = 2'b10,
    MODE_NABS = 2'b11
  } mode_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  // Whether the operand must be negated, given the mode and the operand sign bit.
  function automatic logic effNegOf(mode_t m, logic sign);
    logic r;
    case (m)
      MODE_NEG:  r = 1'b1;
      MODE_ABS:  r = sign;
      MODE_NABS: r = ~sign;
      default:   r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/chunked_negator_if.sv
// Start/busy/done handshake plus operand and result bus of the sign unit.
interface chunked_negator_if #(
  parameter int nrOfBits = 32
);
  import negator_pkg::*;

  logic                start;
  mode_t               mode;
  logic [nrOfBits-1:0] dataX;
  logic                busy;
  logic                done;
  logic [nrOfBits-1:0] result;
  logic                overflow;

  modport master (
    output start, mode, dataX,
    input  busy, done, result, overflow
  );

  modport slave (
    input  start, mode, dataX,
    output busy, done, result, overflow
  );

endinterface

// File: rtl/chunked_negator_chunk.sv
// One chunk of the negator: y = en ? ~x + cin : x, carry-out only when enabled.
module negator_chunk #(
  parameter int chunkBits = 8
) (
  input  logic [chunkBits-1:0] x,
  input  logic                 cin,
  input  logic                 en,
  output logic [chunkBits-1:0] y,
  output logic                 cout
);

  logic [chunkBits:0] sum;

  assign sum  = {1'b0, ~x} + {{chunkBits{1'b0}}, cin};
  assign y    = en ? sum[chunkBits-1:0] : x;
  assign cout = en & sum[chunkBits];

endmodule

// File: rtl/chunked_negator.sv
// Multi-cycle pass/negate/abs/neg-abs unit, one chunk per cycle, LSB chunk first.
module chunked_negator #(
  parameter int nrOfBits  = 32,
  parameter int chunkBits = 8
) (
  input logic              clock,
  input logic              reset,
  chunked_negator_if.slave bus
);
  import negator_pkg::*;

  localparam int nrOfChunks = nrOfBits / chunkBits;
  localparam int idxBits    = (nrOfChunks > 1) ? $clog2(nrOfChunks) : 1;
  localparam logic [idxBits-1:0] lastIdx = idxBits'(nrOfChunks - 1);

  if (nrOfBits % chunkBits != 0) begin : gChunkCheck
    $error("chunked_negator: nrOfBits must be a multiple of chunkBits");
  end

  state_t               state;
  mode_t                modeReg;
  logic [nrOfBits-1:0]  opReg;
  logic [nrOfBits-1:0]  workReg;
  logic [nrOfBits-1:0]  workNext;
  logic [idxBits-1:0]   idx;
  logic                 carry;
  logic                 effNeg;
  logic                 lastChunk;
  logic [chunkBits-1:0] chunkX;
  logic [chunkBits-1:0] chunkY;
  logic                 chunkCout;

  // effNeg is re-derived from the held mode and operand sign instead of being stored.
  assign effNeg    = effNegOf(modeReg, opReg[nrOfBits-1]);
  assign chunkX    = opReg[int'(idx)*chunkBits +: chunkBits];
  assign lastChunk = (idx == lastIdx);

  negator_chunk #(.chunkBits(chunkBits)) uChunk (
    .x    (chunkX),
    .cin  (carry),
    .en   (effNeg),
    .y    (chunkY),
    .cout (chunkCout)
  );

  // Work register with the current chunk merged in; feeds both work and result.
  always_comb begin
    workNext = workReg;
    workNext[int'(idx)*chunkBits +: chunkBits] = chunkY;
  end

  // Handshake FSM, chunk sequencing and all registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      modeReg      <= MODE_PASS;
      opReg        <= '0;
      workReg      <= '0;
      idx          <= '0;
      carry        <= 1'b0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.result   <= '0;
      bus.overflow <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            opReg    <= bus.dataX;
            modeReg  <= bus.mode;
            carry    <= effNegOf(bus.mode, bus.dataX[nrOfBits-1]);
            idx      <= '0;
            bus.busy <= 1'b1;
            state    <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          workReg <= workNext;
          carry   <= effNeg ? chunkCout : carry;
          idx     <= idx + 1'b1;
          if (lastChunk) begin
            bus.result   <= workNext;
            bus.overflow <= effNeg & opReg[nrOfBits-1] & workNext[nrOfBits-1];
            bus.busy     <= 1'b0;
            bus.done     <= 1'b1;
            state        <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
